// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RISC-V core. It sequences fetch,
// decode, execute, memory and write-back, and drives the ALU-control
// and datapath strobes.
module multicycle_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        Branch,
  output logic        ALUSrc,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic [1:0]  Aluop,
  output logic [3:0]  funct,
  output logic        illegal,
  output logic        retire,
  output logic [2:0]  state
);

  localparam int unsigned OP_W    = 7;
  localparam int unsigned F3_W    = 3;
  localparam int unsigned STATE_W = 3;

  localparam logic [OP_W-1:0] OP_R    = 7'b0110011;
  localparam logic [OP_W-1:0] OP_I    = 7'b0010011;
  localparam logic [OP_W-1:0] OP_LOAD = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STOR = 7'b0100011;
  localparam logic [OP_W-1:0] OP_BEQ  = 7'b1100011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef enum logic [STATE_W-1:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXEC    = 3'd2,
    MEM     = 3'd3,
    WB      = 3'd4,
    ILLEGAL = 3'd5
  } state_t;

  state_t          cur_state;
  state_t          next_state;
  logic [OP_W-1:0] op;
  logic [F3_W-1:0] f3;
  logic            f7b5;
  logic            supported;

  // Instruction bits this controller never looks at (registers, immediates).
  logic unused_instr;
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cur_state <= FETCH;
    end else begin
      cur_state <= next_state;
    end
  end

  // Opcode/funct latches, loaded on the accepted fetch cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      op   <= '0;
      f3   <= '0;
      f7b5 <= 1'b0;
    end else if (cur_state == FETCH && imem_ready) begin
      op   <= instr[6:0];
      f3   <= instr[14:12];
      f7b5 <= instr[30];
    end
  end

  assign supported = (op == OP_R) || (op == OP_I) || (op == OP_LOAD) ||
                     (op == OP_STOR) || (op == OP_BEQ);

  // Next-state logic.
  always_comb begin
    next_state = cur_state;
    unique case (cur_state)
      FETCH:   if (imem_ready) next_state = DECODE;
      DECODE:  next_state = supported ? EXEC : ILLEGAL;
      EXEC: begin
        if (op == OP_R || op == OP_I)            next_state = WB;
        else if (op == OP_LOAD || op == OP_STOR) next_state = MEM;
        else                                     next_state = FETCH;
      end
      MEM: begin
        if (dmem_ready) next_state = (op == OP_LOAD) ? WB : FETCH;
      end
      WB:      next_state = FETCH;
      ILLEGAL: next_state = FETCH;
      default: next_state = FETCH;
    endcase
  end

  // Output decode: Moore on state and latches, fetch strobes Mealy on imem_ready.
  always_comb begin
    imem_req   = 1'b0;
    dmem_read  = 1'b0;
    dmem_write = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    Branch     = 1'b0;
    ALUSrc     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    Aluop      = ALU_ADD;
    illegal    = 1'b0;
    retire     = 1'b0;

    if (op == OP_R)      funct = {f7b5, f3};
    else if (op == OP_I) funct = {1'b0, f3};
    else                 funct = 4'b0000;

    unique case (cur_state)
      FETCH: begin
        imem_req = 1'b1;
        IRWrite  = imem_ready;
        PCWrite  = imem_ready;
      end
      DECODE: begin
      end
      EXEC: begin
        if (op == OP_R) begin
          Aluop = ALU_FUNCT;
        end else if (op == OP_I) begin
          Aluop  = ALU_FUNCT;
          ALUSrc = 1'b1;
        end else if (op == OP_LOAD || op == OP_STOR) begin
          ALUSrc = 1'b1;
        end else if (op == OP_BEQ) begin
          Aluop  = ALU_SUB;
          Branch = 1'b1;
          retire = 1'b1;
        end
      end
      MEM: begin
        dmem_read  = (op == OP_LOAD);
        dmem_write = (op == OP_STOR);
        retire     = (op == OP_STOR) && dmem_ready;
      end
      WB: begin
        RegWrite = 1'b1;
        MemtoReg = (op == OP_LOAD);
        retire   = 1'b1;
      end
      ILLEGAL: illegal = 1'b1;
      default: begin
      end
    endcase
  end

  assign state = STATE_W'(cur_state);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed, table-driven bench for multicycle_control.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        imem_ready, dmem_ready;
  logic        imem_req, dmem_read, dmem_write, IRWrite, PCWrite, Branch;
  logic        ALUSrc, MemtoReg, RegWrite, illegal, retire;
  logic [1:0]  Aluop;
  logic [3:0]  funct;
  logic [2:0]  state;

  int tests = 0;
  int fails = 0;

  multicycle_control dut (
    .clk(clk), .reset(reset), .instr(instr), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .imem_req(imem_req), .dmem_read(dmem_read),
    .dmem_write(dmem_write), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .Branch(Branch), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .Aluop(Aluop), .funct(funct), .illegal(illegal),
    .retire(retire), .state(state)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_ANDI = 32'h0050F193;
  localparam logic [31:0] I_LW   = 32'h0000A183;
  localparam logic [31:0] I_SW   = 32'h0030A023;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;

  // Strobe bits: {imem_req,dmem_read,dmem_write,IRWrite,PCWrite,Branch,ALUSrc,MemtoReg,RegWrite}
  localparam logic [8:0] S_NONE  = 9'b000000000;
  localparam logic [8:0] S_REQ   = 9'b100000000;
  localparam logic [8:0] S_FETCH = 9'b100110000;
  localparam logic [8:0] S_RD    = 9'b010000000;
  localparam logic [8:0] S_WR    = 9'b001000000;
  localparam logic [8:0] S_BR    = 9'b000001000;
  localparam logic [8:0] S_SRC   = 9'b000000100;
  localparam logic [8:0] S_M2R   = 9'b000000010;
  localparam logic [8:0] S_RW    = 9'b000000001;

  typedef struct {
    logic        rst;
    logic [31:0] ins;
    logic        ir;
    logic        dr;
    logic        chk;
    logic [19:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic void row(input logic rst, input logic [31:0] ins,
                              input logic ir, input logic dr, input logic chk,
                              input logic [2:0] st, input logic [8:0] s,
                              input logic [1:0] aop, input logic [3:0] fn,
                              input logic ill, input logic ret);
    vec_t v;
    v.rst = rst; v.ins = ins; v.ir = ir; v.dr = dr; v.chk = chk;
    v.exp = {st, s, aop, fn, ill, ret};
    tbl.push_back(v);
  endfunction

  function automatic logic [19:0] observed();
    return {state, imem_req, dmem_read, dmem_write, IRWrite, PCWrite, Branch,
            ALUSrc, MemtoReg, RegWrite, Aluop, funct, illegal, retire};
  endfunction

  // Starts at a falling edge in FETCH; counts cycles up to retire or illegal.
  task automatic run_lat(input string name, input logic [31:0] w,
                         input int exp_cyc, input logic exp_ill);
    int   cyc;
    logic ill;
    cyc = 0;
    ill = 1'b0;
    @(negedge clk);
    instr = w; imem_ready = 1'b1; dmem_ready = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      #1;
      if (retire || illegal) begin
        cyc = c;
        ill = illegal;
        break;
      end
      @(negedge clk);
    end
    tests++;
    if (cyc != exp_cyc || ill != exp_ill) begin
      fails++;
      $display("FAIL lat_%s: got %0d cycles illegal=%0b, want %0d cycles illegal=%0b",
               name, cyc, ill, exp_cyc, exp_ill);
    end
  endtask

  initial begin
    reset = 1'b0; instr = I_ADD; imem_ready = 1'b0; dmem_ready = 1'b1;

    // reset, then reset state with fetch stalled
    row(0, I_ADD, 0, 1, 0, 3'd0, S_NONE, 2'b00, 4'b0000, 0, 0);
    row(1, I_ADD, 0, 1, 1, 3'd0, S_REQ,  2'b00, 4'b0000, 0, 0);
    // add
    row(1, I_ADD, 1, 1, 1, 3'd0, S_FETCH, 2'b00, 4'b0000, 0, 0);
    row(1, I_ADD, 1, 1, 1, 3'd1, S_NONE,  2'b00, 4'b0000, 0, 0);
    row(1, I_ADD, 1, 1, 1, 3'd2, S_NONE,  2'b10, 4'b0000, 0, 0);
    row(1, I_ADD, 1, 1, 1, 3'd4, S_RW,    2'b00, 4'b0000, 0, 1);
    // sub
    row(1, I_SUB, 1, 1, 1, 3'd0, S_FETCH, 2'b00, 4'b0000, 0, 0);
    row(1, I_SUB, 1, 1, 1, 3'd1, S_NONE,  2'b00, 4'b1000, 0, 0);
    row(1, I_SUB, 1, 1, 1, 3'd2, S_NONE,  2'b10, 4'b1000, 0, 0);
    row(1, I_SUB, 1, 1, 1, 3'd4, S_RW,    2'b00, 4'b1000, 0, 1);
    // andi
    row(1, I_ANDI, 1, 1, 1, 3'd0, S_FETCH, 2'b00, 4'b1000, 0, 0);
    row(1, I_ANDI, 1, 1, 1, 3'd1, S_NONE,  2'b00, 4'b0111, 0, 0);
    row(1, I_ANDI, 1, 1, 1, 3'd2, S_SRC,   2'b10, 4'b0111, 0, 0);
    row(1, I_ANDI, 1, 1, 1, 3'd4, S_RW,    2'b00, 4'b0111, 0, 1);
    // lw with three data-memory wait states
    row(1, I_LW, 1, 1, 1, 3'd0, S_FETCH,     2'b00, 4'b0111, 0, 0);
    row(1, I_LW, 1, 1, 1, 3'd1, S_NONE,      2'b00, 4'b0000, 0, 0);
    row(1, I_LW, 1, 0, 1, 3'd2, S_SRC,       2'b00, 4'b0000, 0, 0);
    row(1, I_LW, 1, 0, 1, 3'd3, S_RD,        2'b00, 4'b0000, 0, 0);
    row(1, I_LW, 1, 0, 1, 3'd3, S_RD,        2'b00, 4'b0000, 0, 0);
    row(1, I_LW, 1, 0, 1, 3'd3, S_RD,        2'b00, 4'b0000, 0, 0);
    row(1, I_LW, 1, 1, 1, 3'd3, S_RD,        2'b00, 4'b0000, 0, 0);
    row(1, I_LW, 1, 1, 1, 3'd4, S_RW|S_M2R,  2'b00, 4'b0000, 0, 1);
    // sw
    row(1, I_SW, 1, 1, 1, 3'd0, S_FETCH, 2'b00, 4'b0000, 0, 0);
    row(1, I_SW, 1, 1, 1, 3'd1, S_NONE,  2'b00, 4'b0000, 0, 0);
    row(1, I_SW, 1, 1, 1, 3'd2, S_SRC,   2'b00, 4'b0000, 0, 0);
    row(1, I_SW, 1, 1, 1, 3'd3, S_WR,    2'b00, 4'b0000, 0, 1);
    // beq
    row(1, I_BEQ, 1, 1, 1, 3'd0, S_FETCH, 2'b00, 4'b0000, 0, 0);
    row(1, I_BEQ, 1, 1, 1, 3'd1, S_NONE,  2'b00, 4'b0000, 0, 0);
    row(1, I_BEQ, 1, 1, 1, 3'd2, S_BR,    2'b01, 4'b0000, 0, 1);
    // illegal opcode after two fetch wait states
    row(1, I_BAD, 0, 1, 1, 3'd0, S_REQ,   2'b00, 4'b0000, 0, 0);
    row(1, I_BAD, 0, 1, 1, 3'd0, S_REQ,   2'b00, 4'b0000, 0, 0);
    row(1, I_BAD, 1, 1, 1, 3'd0, S_FETCH, 2'b00, 4'b0000, 0, 0);
    row(1, I_BAD, 1, 1, 1, 3'd1, S_NONE,  2'b00, 4'b0000, 0, 0);
    row(1, I_BAD, 1, 1, 1, 3'd5, S_NONE,  2'b00, 4'b0000, 1, 0);
    row(1, I_BAD, 0, 1, 1, 3'd0, S_REQ,   2'b00, 4'b0000, 0, 0);
    // reset while a store is waiting in MEM
    row(1, I_SW, 1, 1, 1, 3'd0, S_FETCH, 2'b00, 4'b0000, 0, 0);
    row(1, I_SW, 1, 1, 1, 3'd1, S_NONE,  2'b00, 4'b0000, 0, 0);
    row(1, I_SW, 1, 0, 1, 3'd2, S_SRC,   2'b00, 4'b0000, 0, 0);
    row(0, I_SW, 0, 0, 1, 3'd3, S_WR,    2'b00, 4'b0000, 0, 0);
    row(1, I_SW, 0, 1, 1, 3'd0, S_REQ,   2'b00, 4'b0000, 0, 0);
    // reset in EXEC of sub clears the funct latches
    row(1, I_SUB, 1, 1, 1, 3'd0, S_FETCH, 2'b00, 4'b0000, 0, 0);
    row(1, I_SUB, 1, 1, 1, 3'd1, S_NONE,  2'b00, 4'b1000, 0, 0);
    row(0, I_SUB, 1, 1, 1, 3'd2, S_NONE,  2'b10, 4'b1000, 0, 0);
    row(1, I_SUB, 0, 1, 1, 3'd0, S_REQ,   2'b00, 4'b0000, 0, 0);

    foreach (tbl[i]) begin
      @(negedge clk);
      reset = tbl[i].rst; instr = tbl[i].ins;
      imem_ready = tbl[i].ir; dmem_ready = tbl[i].dr;
      #1;
      if (tbl[i].chk) begin
        tests++;
        if (observed() !== tbl[i].exp) begin
          fails++;
          $display("FAIL row_%0d: got %b, want %b", i, observed(), tbl[i].exp);
        end
      end
    end

    // zero-wait FETCH-to-retire latencies
    run_lat("beq",  I_BEQ,  3, 1'b0);
    run_lat("add",  I_ADD,  4, 1'b0);
    run_lat("andi", I_ANDI, 4, 1'b0);
    run_lat("sw",   I_SW,   4, 1'b0);
    run_lat("lw",   I_LW,   5, 1'b0);
    run_lat("bad",  I_BAD,  3, 1'b1);
    run_lat("sub",  I_SUB,  4, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Exclusivity of completion and memory strobes, checked every cycle.
  always @(negedge clk) begin
    #2;
    if (reset === 1'b1) begin
      if ((retire && illegal) || (dmem_read && dmem_write)) begin
        tests++;
        fails++;
        $display("FAIL exclusive: retire=%0b illegal=%0b rd=%0b wr=%0b, want no overlap",
                 retire, illegal, dmem_read, dmem_write);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, want finish");
    $fatal(1);
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle RISC-V core. It fetches instructions over a ready handshake, latches opcode and funct fields, and sequences each instruction through decode, execute, memory and write-back. It drives `Aluop` and `funct` into the ALU control decoder, plus all datapath and memory strobes. Supported instructions: R-type, I-type ALU, `lw`, `sw`, `beq`; every other opcode is flagged illegal.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `instr`  in  32  instruction word; valid when `imem_ready`=1 in FETCH.
- `imem_ready`  in  1  instruction memory has `instr` valid this cycle.
- `dmem_ready`  in  1  data memory access completes this cycle.
- `imem_req`  out  1  instruction fetch request.
- `dmem_read`  out  1  data load request.
- `dmem_write`  out  1  data store request.
- `IRWrite`  out  1  datapath loads the instruction register.
- `PCWrite`  out  1  datapath loads PC+4.
- `Branch`  out  1  datapath loads the branch target if ALU zero is set.
- `ALUSrc`  out  1  0 selects rs2, 1 selects immediate.
- `MemtoReg`  out  1  write-back source is memory.
- `RegWrite`  out  1  register file write enable.
- `Aluop`  out  2  to ALU control: 00 add, 01 sub/compare, 10 decode funct.
- `funct`  out  4  to ALU control.
- `illegal`  out  1  one-cycle pulse on an unsupported opcode.
- `retire`  out  1  one-cycle pulse when an instruction completes.
- `state`  out  3  current state, for debug.

## Operation
State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ILLEGAL=5.

**Latches.** On the FETCH edge with `imem_ready`=1, latch `op`=instr[6:0], `f3`=instr[14:12], `f7b5`=instr[30].

**`funct` output.** Driven continuously from the latches:
- R-type (0110011): {f7b5,f3}.
- I-ALU (0010011): {0,f3}. `f7b5` is ignored, so `srai` is unsupported.
- All other opcodes: 0000.

**States and transitions:**
- **FETCH:** `imem_req`=1, `Aluop`=00.
  - `imem_ready`=0: stay in FETCH.
  - `imem_ready`=1: `IRWrite`=1 and `PCWrite`=1 in that same cycle (Mealy on ready), then go to DECODE.
- **DECODE:** no strobes. Next state is EXEC for the 5 supported opcodes, else ILLEGAL.
- **EXEC:**
  - R-type: `Aluop`=10, `ALUSrc`=0, then WB.
  - I-ALU: `Aluop`=10, `ALUSrc`=1, then WB.
  - lw/sw: `Aluop`=00, `ALUSrc`=1, then MEM.
  - beq: `Aluop`=01, `ALUSrc`=0, `Branch`=1, `retire`=1, then FETCH.
- **MEM:**
  - Hold `dmem_read` (lw) or `dmem_write` (sw) while `dmem_ready`=0.
  - On `dmem_ready`=1: lw goes to WB; sw pulses `retire` and goes to FETCH.
- **WB:** `RegWrite`=1, `MemtoReg`=1 for lw only, `retire`=1, then FETCH.
- **ILLEGAL:** `illegal`=1, no register or memory writes, then FETCH. PC has already advanced.

**Output defaults.** Every strobe not listed for a state is 0. Outputs are Moore functions of `state` and the latches, except `IRWrite`/`PCWrite` in FETCH, which also depend on `imem_ready`.

## Timing
**Reset.**
- An edge with `reset`=0 forces `state`=FETCH and clears the latches to 0.
- First cycle after reset: `imem_req`=1; all other strobes 0; `Aluop`=00, `funct`=0000.
- Reset has priority over every transition.
- Reset mid-MEM drops `dmem_read`/`dmem_write` in the next cycle. No `retire` and no `RegWrite` for the aborted instruction.

**Zero-wait latency in cycles, FETCH to retire:**
- beq: 3.
- R-type, I-ALU, sw: 4.
- lw: 5.
- Illegal opcode: 3, with no `retire`.

**Wait states.** Each cycle `imem_ready` or `dmem_ready` stays low adds exactly one cycle. Strobes stay stable during the wait.

**Handshake inputs outside their state.** `imem_ready` outside FETCH and `dmem_ready` outside MEM are ignored.

**Strobe exclusivity.**
- `retire` and `illegal` are never both 1.
- `dmem_read` and `dmem_write` are never both 1.

## Test plan
- add, 0x002081B3, ready always 1: `state` 0,1,2,4. In EXEC `Aluop`=10, `funct`=0000. `RegWrite`=1 and `retire`=1 in cycle 4 only.
- sub 0x402081B3, then andi 0x0050F193: `funct`=1000 with `ALUSrc`=0, then `funct`=0111 with `ALUSrc`=1. `Aluop`=10 in both EXEC states.
- lw 0x0000A183 with `dmem_ready` low for 3 cycles in MEM: `dmem_read`=1 for exactly 4 cycles. WB shows `RegWrite`=1, `MemtoReg`=1. Total 8 cycles.
- sw 0x0030A023, then beq 0x00208463: sw gives `Aluop`=00, one `dmem_write` cycle, `RegWrite` never 1. beq gives `Aluop`=01, `Branch`=1 and `retire`=1 in cycle 3.
- `instr`=0xFFFFFFFF, with `imem_ready` held low 2 cycles in FETCH first: `IRWrite`/`PCWrite` only on the ready cycle. `illegal`=1 one cycle in `state`=5, then FETCH. No `retire`, no `RegWrite`.
- `reset`=0 while in MEM with `dmem_write`=1: next cycle `state`=0, `dmem_write`=0, `funct`=0000, `imem_req`=1, no `retire`.
